// File: rtl/mem_bist_pkg.sv
// Shared definitions for the March C- memory BIST: FSM/phase encodings and per-element descriptors.
// Pure declarations; no latency or flow-control of its own.
package mem_bist_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    typedef enum logic [1:0] {PH_RD, PH_RW, PH_WR} phase_t;

    localparam int NUM_ELEM = 6;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    typedef struct packed {
        logic down;
        logic rd_inv;
        logic wr_inv;
        logic has_rd;
        logic has_wr;
    } elem_desc_t;

    function automatic elem_desc_t elem_desc(input logic [2:0] e);
        elem_desc_t d;
        d = '0;
        case (e)
            M0: d = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b0, has_wr: 1'b1};
            M1: d = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
            M2: d = '{down: 1'b0, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
            M3: d = '{down: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
            M4: d = '{down: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
            M5: d = '{down: 1'b1, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b0};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_march_bist_if.sv
// RAM-side bus of the BIST engine: the engine is master, the RAM instance is slave.
// No flow control: one op per cycle, read data returned after the RAM's fixed latency.
interface mem_march_bist_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/march_addr_gen.sv
// March sequencer: address counter, element advance and read/read-wait/write op phasing.
// One phase step per enabled cycle; rd_cmp_o marks the final cycle of a read op, last_o the final op.
module march_addr_gen
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [2:0]        elem_o,
    output phase_t            phase_o,
    output logic              rd_cmp_o,
    output logic              last_o
);
    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        elem_q, elem_d;
    phase_t            phase_q, phase_d;
    logic              cur_down, cur_has_rd, cur_has_wr, nxt_down, nxt_has_rd;
    logic              tc, rd_end, addr_step;

    always_comb begin
        cur_down   = elem_desc(elem_q).down;
        cur_has_rd = elem_desc(elem_q).has_rd;
        cur_has_wr = elem_desc(elem_q).has_wr;
        nxt_down   = elem_desc(elem_q + 3'd1).down;
        nxt_has_rd = elem_desc(elem_q + 3'd1).has_rd;
        tc         = cur_down ? (addr_q == '0) : (addr_q == '1);
        rd_end     = (phase_q == PH_RW) || ((phase_q == PH_RD) && (READ_LAT == 0));
        addr_step  = (phase_q == PH_WR) || (rd_end && !cur_has_wr);
        last_o     = addr_step && tc && (elem_q == LAST_ELEM);
        rd_cmp_o   = rd_end;

        addr_d  = addr_q;
        elem_d  = elem_q;
        phase_d = phase_q;
        if (init_i) begin
            // M0 is write-only and ascending
            addr_d  = '0;
            elem_d  = M0;
            phase_d = PH_WR;
        end else if (en_i) begin
            if ((phase_q == PH_RD) && (READ_LAT != 0)) begin
                phase_d = PH_RW;
            end else if (rd_end && cur_has_wr) begin
                phase_d = PH_WR;
            end else if (addr_step) begin
                if (!tc) begin
                    addr_d  = cur_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                    phase_d = cur_has_rd ? PH_RD : PH_WR;
                end else if (elem_q != LAST_ELEM) begin
                    elem_d  = elem_q + 3'd1;
                    addr_d  = nxt_down ? '1 : '0;
                    phase_d = nxt_has_rd ? PH_RD : PH_WR;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            elem_q  <= M0;
            phase_q <= PH_WR;
        end else begin
            addr_q  <= addr_d;
            elem_q  <= elem_d;
            phase_q <= phase_d;
        end
    end

    assign addr_o  = addr_q;
    assign elem_o  = elem_q;
    assign phase_o = phase_q;
endmodule

// File: rtl/mem_march_bist.sv
// March C- memory BIST top: run control, pattern generation, compare, error count and first-fail capture.
// Test takes DEPTH*(10+5*READ_LAT) cycles after start; start is ignored while running, no RAM backpressure.
module mem_march_bist
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 16,
    parameter int READ_LAT     = 0,
    parameter int CNT_W        = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    mem_march_bist_if.master       ram,
    output logic                   busy,
    output logic                   finish,
    output logic                   error,
    output logic [CNT_W-1:0]       err_count,
    output logic [ADDR_W-1:0]      fail_addr,
    output logic [DATA_W-1:0]      fail_exp,
    output logic [DATA_W-1:0]      fail_act,
    output logic [2:0]             fail_elem
);
    state_t            state_q, state_d;
    logic              mode_q;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        elem;
    phase_t            phase;
    logic              rd_cmp, last, run, accept, inv, mismatch;
    logic [DATA_W-1:0] bg, pattern;

    assign run    = (state_q == ST_RUN);
    assign accept = !run && start;

    march_addr_gen #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) u_gen (
        .clk      (clk),
        .rst      (rst),
        .init_i   (accept),
        .en_i     (run),
        .addr_o   (addr),
        .elem_o   (elem),
        .phase_o  (phase),
        .rd_cmp_o (rd_cmp),
        .last_o   (last)
    );

    // Checkerboard: even addresses get 1s on odd bits, odd addresses the reverse
    always_comb begin
        bg = '0;
        for (int i = 0; i < DATA_W; i++) begin
            bg[i] = mode_q & (((i % 2) == 1) ^ addr[0]);
        end
        inv      = (phase == PH_WR) ? elem_desc(elem).wr_inv : elem_desc(elem).rd_inv;
        pattern  = bg ^ {DATA_W{inv}};
        mismatch = run && rd_cmp && (ram.mem_rdata != pattern);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
            ST_RUN: if (last || ((STOP_ON_FAIL != 0) && mismatch)) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        busy          = run;
        finish        = (state_q == ST_DONE);
        ram.mem_we    = run && (phase == PH_WR);
        ram.mem_addr  = addr;
        ram.mem_wdata = run ? pattern : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) mode_q <= mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error     <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
            fail_elem <= '0;
        end else if (accept) begin
            error     <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
            fail_elem <= '0;
        end else if (mismatch) begin
            error <= 1'b1;
            if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
            if (!error) begin
                fail_addr <= addr;
                fail_exp  <= pattern;
                fail_act  <= ram.mem_rdata;
                fail_elem <= elem;
            end
        end
    end
endmodule

// File: tb/tb_mem_march_bist.sv
// Bench: three engines (comb RAM, comb RAM with stop-on-fail, registered RAM) run side by side on 8x8 RAM models.
module tb_mem_march_bist;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0, fault = 1'b0;
    always #5 clk = ~clk;

    logic       busy[3], finish[3], error[3], we[3];
    logic [7:0] cnt[3], fexp[3], fact[3], wdata[3];
    logic [2:0] faddr[3], felem[3], addr[3];
    logic [63:0] ram[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_march_bist_if #(.ADDR_W(3), .DATA_W(8)) bus();
        logic [63:0] mem_q;
        logic [7:0]  rd_raw;

        mem_march_bist #(.ADDR_W(3), .DATA_W(8), .READ_LAT(g == 2 ? 1 : 0), .CNT_W(8),
                         .STOP_ON_FAIL(g == 1 ? 1 : 0)) u_dut (
            .clk(clk), .rst(rst), .start(start), .mode(mode), .ram(bus),
            .busy(busy[g]), .finish(finish[g]), .error(error[g]), .err_count(cnt[g]),
            .fail_addr(faddr[g]), .fail_exp(fexp[g]), .fail_act(fact[g]), .fail_elem(felem[g])
        );

        always @(posedge clk) if (bus.mem_we) mem_q[{bus.mem_addr, 3'b000} +: 8] <= bus.mem_wdata;
        // Stuck-at-1 on bit 3 of address 5 when fault is enabled
        assign rd_raw = mem_q[{bus.mem_addr, 3'b000} +: 8]
                      | ((fault && bus.mem_addr == 3'd5) ? 8'h08 : 8'h00);
        if (g == 2) begin : g_reg
            logic [7:0] rq;
            always @(posedge clk) rq <= rd_raw;
            assign bus.mem_rdata = rq;
        end else begin : g_comb
            assign bus.mem_rdata = rd_raw;
        end
        assign we[g]    = bus.mem_we;
        assign addr[g]  = bus.mem_addr;
        assign wdata[g] = bus.mem_wdata;
        assign ram[g]   = mem_q;
    end

    logic [7:0] log2[$], log3[$];
    always @(posedge clk) begin
        if (we[2] && addr[2] == 3'd2) log2.push_back(wdata[2]);
        if (we[2] && addr[2] == 3'd3) log3.push_back(wdata[2]);
    end

    int n_cmp = 0, n_bad = 0;
    int fin_e[3];
    int b_late;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Starts a run at the next edge (edge 0) and records the edge number at which each engine finishes
    task automatic do_run(input logic md, input logic flt, input int poke);
        fault = flt;
        log2.delete();
        log3.delete();
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("d%0d busy@start", g), busy[g], 1);
            chk($sformatf("d%0d finish cleared@start", g), finish[g], 0);
            chk($sformatf("d%0d error cleared@start", g), error[g], 0);
            chk($sformatf("d%0d count cleared@start", g), cnt[g], 0);
        end
        fin_e  = '{-1, -1, -1};
        b_late = 0;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            if (fin_e[1] >= 0 && we[1]) b_late++;
            for (int g = 0; g < 3; g++) if (fin_e[g] < 0 && finish[g]) fin_e[g] = e;
            start = (e == poke);
            if (fin_e[0] >= 0 && fin_e[1] >= 0 && fin_e[2] >= 0) break;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic            md;
        logic            flt;
        int              poke;
        logic [2:0][7:0] fin;   // [0]=comb, [1]=stop-on-fail, [2]=registered
        logic            err;
        logic [2:0][7:0] cnt;
        logic [2:0]      fa;
        logic [7:0]      fe;
        logic [7:0]      fx;
        logic [2:0]      fel;
    } vec_t;
    vec_t vt[4];

    initial begin
        logic [7:0] exp_w;
        vt[0] = '{md: 0, flt: 0, poke: 0,  fin: {8'd120, 8'd80, 8'd80}, err: 0, cnt: {8'd0, 8'd0, 8'd0},
                  fa: 3'd0, fe: 8'h00, fx: 8'h00, fel: 3'd0};
        vt[1] = '{md: 0, flt: 1, poke: 10, fin: {8'd120, 8'd19, 8'd80}, err: 1, cnt: {8'd3, 8'd1, 8'd3},
                  fa: 3'd5, fe: 8'h00, fx: 8'h08, fel: 3'd1};
        vt[2] = '{md: 1, flt: 0, poke: 0,  fin: {8'd120, 8'd80, 8'd80}, err: 0, cnt: {8'd0, 8'd0, 8'd0},
                  fa: 3'd0, fe: 8'h00, fx: 8'h00, fel: 3'd0};
        vt[3] = '{md: 1, flt: 1, poke: 0,  fin: {8'd120, 8'd19, 8'd80}, err: 1, cnt: {8'd3, 8'd1, 8'd3},
                  fa: 3'd5, fe: 8'h55, fx: 8'h5D, fel: 3'd1};

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy[0], 0);
        chk("reset finish", finish[0], 0);
        chk("reset error", error[0], 0);
        chk("reset count", cnt[0], 0);
        chk("reset we", we[0], 0);
        chk("reset addr", addr[0], 0);
        chk("reset wdata", wdata[0], 0);
        chk("reset fail_addr", faddr[0], 0);
        chk("reset fail_elem", felem[2], 0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_run(vt[i].md, vt[i].flt, vt[i].poke);
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("v%0d d%0d finish edge", i, g), fin_e[g], vt[i].fin[g]);
                chk($sformatf("v%0d d%0d busy", i, g), busy[g], 0);
                chk($sformatf("v%0d d%0d error", i, g), error[g], vt[i].err);
                chk($sformatf("v%0d d%0d err_count", i, g), cnt[g], vt[i].cnt[g]);
                chk($sformatf("v%0d d%0d fail_addr", i, g), faddr[g], vt[i].fa);
                chk($sformatf("v%0d d%0d fail_exp", i, g), fexp[g], vt[i].fe);
                chk($sformatf("v%0d d%0d fail_act", i, g), fact[g], vt[i].fx);
                chk($sformatf("v%0d d%0d fail_elem", i, g), felem[g], vt[i].fel);
            end
            chk($sformatf("v%0d stop-on-fail writes after finish", i), b_late, 0);
            for (int k = 0; k < 8; k++) begin
                exp_w = vt[i].md ? ((k % 2 == 1) ? 8'h55 : 8'hAA) : 8'h00;
                chk($sformatf("v%0d ram0[%0d]", i, k), ram[0][k*8 +: 8], exp_w);
                chk($sformatf("v%0d ram2[%0d]", i, k), ram[2][k*8 +: 8], exp_w);
            end
            if (vt[i].md) begin
                chk($sformatf("v%0d addr2 write#0", i), log2[0], 8'hAA);
                chk($sformatf("v%0d addr2 write#1", i), log2[1], 8'h55);
                chk($sformatf("v%0d addr3 write#0", i), log3[0], 8'h55);
                chk($sformatf("v%0d addr3 write#1", i), log3[1], 8'hAA);
            end
        end

        // Asynchronous abort in op cycle 30 (M2 write of address 2)
        fault = 1'b0;
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        chk("cycle30 we before reset", we[0], 1);
        chk("cycle30 addr before reset", addr[0], 2);
        #2 rst = 1'b1;
        #1;
        chk("async reset we", we[0], 0);
        chk("async reset busy", busy[0], 0);
        chk("async reset finish", finish[0], 0);
        chk("async reset we regRAM", we[2], 0);
        @(negedge clk) rst = 1'b0;
        do_run(1'b0, 1'b0, 0);
        chk("post-reset finish edge", fin_e[0], 80);
        chk("post-reset finish edge regRAM", fin_e[2], 120);
        chk("post-reset error", error[0], 0);
        for (int k = 0; k < 8; k++) chk($sformatf("post-reset ram0[%0d]", k), ram[0][k*8 +: 8], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_march_bist.md
Name: mem_march_bist

Overview:
- Parametrised memory built-in self-test engine; the next generation of the team's pattern-write/read-back memory tester.
- Drives a single-port synchronous-write RAM through the March C- algorithm in ascending and descending address order.
- Supports solid and checkerboard data backgrounds, configurable read latency, an error counter, first-failure capture and optional stop-on-fail.
- Sits between the system top level (start/finish/error) and the RAM instance; it replaces the separate control-SM-plus-support-logic pair.

Parameters:
- ADDR_W, 15, address width; DEPTH = 2**ADDR_W.
- DATA_W, 16, memory word width.
- READ_LAT, 0, RAM read latency in cycles. Legal values: 0 (combinational spo) or 1 (registered output).
- CNT_W, 8, error counter width.
- STOP_ON_FAIL, 0, when 1 the test ends at the first mismatch.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled request to begin a test.
- mode  in  1  0 = solid background, 1 = checkerboard; sampled with start.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  test in progress.
- finish  out  1  test complete; held until the next accepted start.
- error  out  1  sticky: at least one mismatch seen.
- err_count  out  CNT_W  number of mismatches; saturates at all-ones.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_exp  out  DATA_W  expected data at the first mismatch.
- fail_act  out  DATA_W  actual data at the first mismatch.
- fail_elem  out  3  march element index (0-5) of the first mismatch.

Behaviour:
- Reset (async): state IDLE. mem_we, busy, finish and error are 0. All counters and capture registers are 0. mem_addr and mem_wdata are 0.
- States: IDLE, RUN, DONE.
  - IDLE or DONE with start=1 at an edge: go to RUN. That edge latches mode and clears error, err_count, the fail_* registers and finish. busy=1.
  - start while in RUN is ignored.
- Elements, with B = background and ~B = its inverse:
  - M0 up: w B
  - M1 up: r B, w ~B
  - M2 up: r ~B, w B
  - M3 down: r B, w ~B
  - M4 down: r ~B, w B
  - M5 down: r B
- Address order: "up" runs 0 to DEPTH-1; "down" runs DEPTH-1 to 0. The address wraps into the next element with no idle cycle.
- Background: mode 0 gives B = all zeros. Mode 1 gives bit i of B = (i mod 2) XOR mem_addr[0].
- Write op: 1 cycle. mem_we=1 and mem_wdata = pattern; the write takes effect at the edge.
- Read op: 1+READ_LAT cycles. mem_we=0 and mem_addr is held. mem_rdata is compared against the expected pattern at the final edge of the op.
- mem_wdata on read cycles equals the expected pattern.
- Total test length T = DEPTH*(10+5*READ_LAT) op cycles. The first op cycle directly follows the start-sampling edge. On edge T after that edge: state DONE, finish=1, busy=0, mem_we=0.
- Mismatch handling:
  - Every mismatch sets error and increments err_count, saturating.
  - fail_* registers load only on the first mismatch.
  - With STOP_ON_FAIL=1, the mismatch edge itself enters DONE: finish=1 and no further RAM ops are issued.
- Reset mid-run: aborts immediately (async). mem_we drops in the same instant. Memory contents are undefined afterwards.
- finish, error and the fail_* registers hold in DONE until the next accepted start or reset.

Decomposition:
- Shared package (mem_bist_pkg) holds:
  - state encoding (IDLE/RUN/DONE);
  - element index constants M0..M5;
  - per-element descriptors: direction, read-expected polarity, write polarity, has-read, has-write;
  - NUM_ELEM = 6.
- One natural sub-module, march_addr_gen, handles:
  - up/down address counter with terminal-count flag;
  - element advance;
  - op phase (read / read-wait / write) sequencing.
- Compare, counting and capture stay in mem_march_bist.

Test Plan:
1. ADDR_W=3, DATA_W=8, READ_LAT=0, mode 0, fault-free RAM model, start pulse -> finish on edge 80; error=0; err_count=0; final RAM contents all 0x00.
2. Same setup, RAM addr 5 bit 3 stuck-at-1 -> finish on edge 80; error=1; err_count=3; fail_addr=5; fail_exp=0x00; fail_act=0x08; fail_elem=1.
3. Same fault with STOP_ON_FAIL=1 -> finish on edge 19; err_count=1; no mem_we after edge 19.
4. READ_LAT=1 registered RAM model, mode 1, fault-free -> finish on edge 120; error=0. Addr 2 is written 0xAA then 0x55; addr 3 is written 0x55 then 0xAA.
5. Assert rst during op cycle 30 -> mem_we=0, busy=0, finish=0 asynchronously. Deassert, start again -> clean run, finish on edge 80.
6. Pulse start again at cycle 10 of a run -> ignored; finish still on edge 80. Start while in DONE -> finish, error and err_count cleared on that edge; new run proceeds.
